// File: rtl/escalonador_vetores.sv
// Two-requester vector-op scheduler: OCIOSO -> EXECUTA -> ENTREGA.
// Define PRIORIDADE_FIXA_EN for fixed priority (requester 0 wins); default is round-robin.
module escalonador_vetores (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] a0,
  input  logic [2:0] b0,
  input  logic [2:0] a1,
  input  logic [2:0] b1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       valido,
  output logic [5:0] resultado,
  output logic       origem,
  output logic       ocupado
);

  typedef enum logic [1:0] {
    OCIOSO,
    EXECUTA,
    ENTREGA
  } estado_t;

  estado_t estado, prox;

  logic       any;
  logic       pick1;
  logic [2:0] a_q, b_q;
  logic [1:0] op_q;
  logic       src_q;
  logic [5:0] res_c;

  assign any = req0 | req1;

`ifdef PRIORIDADE_FIXA_EN
  assign pick1 = req1 & ~req0;
`else
  logic ultimo;
  // on a tie, grant the index that was not served last
  assign pick1 = req1 & (~req0 | ~ultimo);
`endif

  assign ocupado = (estado != OCIOSO);

  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:  if (any) prox = EXECUTA;
      EXECUTA: prox = ENTREGA;
      ENTREGA: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_comb begin
    res_c = 6'b000000;
    case (op_q)
      2'b00:   res_c = {3'b000, a_q | b_q};
      2'b01:   res_c = {5'b00000, (|a_q) || (|b_q)};
      2'b10:   res_c = ~{a_q, b_q};
      default: res_c = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= 3'b000;
      b_q       <= 3'b000;
      op_q      <= 2'b00;
      src_q     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      valido    <= 1'b0;
      resultado <= 6'b000000;
      origem    <= 1'b0;
`ifndef PRIORIDADE_FIXA_EN
      ultimo    <= 1'b1;
`endif
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valido <= 1'b0;
      if (estado == OCIOSO && any) begin
        a_q   <= pick1 ? a1 : a0;
        b_q   <= pick1 ? b1 : b0;
        op_q  <= pick1 ? op1 : op0;
        src_q <= pick1;
        gnt0  <= ~pick1;
        gnt1  <= pick1;
`ifndef PRIORIDADE_FIXA_EN
        ultimo <= pick1;
`endif
      end
      if (estado == EXECUTA) begin
        resultado <= res_c;
        origem    <= src_q;
        valido    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_escalonador_vetores.sv
// Scoreboard bench for escalonador_vetores: expected grants/results queued
// at stimulus time, checked by a negedge monitor.
module tb_escalonador_vetores;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic       gnt0, gnt1, valido, origem, ocupado;
  logic [5:0] resultado;

  int total = 0;
  int bad   = 0;
  int ult   = 1;

  bit       gq[$];
  bit [6:0] rq[$];

  escalonador_vetores dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1),
    .valido(valido), .resultado(resultado),
    .origem(origem), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] modelo(input logic [2:0] a,
                                        input logic [2:0] b,
                                        input logic [1:0] op);
    logic [5:0] r;
    if (op == 2'd0)      r = {3'd0, a | b};
    else if (op == 2'd1) r = (a != 0 || b != 0) ? 6'd1 : 6'd0;
    else if (op == 2'd2) r = 6'd63 - {a, b};
    else                 r = 6'd0;
    return r;
  endfunction

  function automatic int vencedor(input bit both);
`ifdef PRIORIDADE_FIXA_EN
    return 0;
`else
    return (both && ult == 0) ? 1 : (both ? 0 : -1);
`endif
  endfunction

  always @(negedge clk) begin
    chk("gnt_excl", gnt0 & gnt1, 0);
    if (gnt0 | gnt1) begin
      if (gq.size() == 0) chk("gnt_extra", {gnt1, gnt0}, 0);
      else begin
        bit e;
        e = gq.pop_front();
        chk("gnt1", gnt1, e);
        chk("gnt0", gnt0, !e);
      end
    end
    if (valido) begin
      if (rq.size() == 0) chk("val_extra", valido, 0);
      else begin
        bit [6:0] e;
        e = rq.pop_front();
        chk("res", resultado, e[5:0]);
        chk("org", origem, e[6]);
      end
    end
  end

  task automatic wait_gnt(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (gnt0 | gnt1) break;
    end
    chk("gnt_seen", gnt0 | gnt1, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (rq.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", rq.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ult = 1;
  endtask

  task automatic issue(input int idx, input logic [2:0] a,
                       input logic [2:0] b, input logic [1:0] op);
    int n;
    gq.push_back(idx[0]);
    rq.push_back({idx[0], modelo(a, b, op)});
    if (idx == 0) begin a0 = a; b0 = b; op0 = op; req0 = 1; end
    else          begin a1 = a; b1 = b; op1 = op; req1 = 1; end
    wait_gnt(n);
    chk("gnt_lat", n, 1);
    chk("ocup", ocupado, 1);
    req0 = 0; req1 = 0;
    a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1;
    ult = idx;
    drain();
  endtask

  initial begin
    int n, w;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
    req0 = 0; req1 = 0;
    rst_n = 1'b0;
    #12;
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_val", valido, 0);
    chk("rst_res", resultado, 0);
    chk("rst_org", origem, 0);
    chk("rst_ocup", ocupado, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, 3'b101, 3'b010, 2'b00);
    issue(1, 3'b000, 3'b000, 2'b01);
    issue(1, 3'b000, 3'b100, 2'b01);
    chk("hold_res", resultado, 6'b000001);
    chk("hold_org", origem, 1);

    do_reset();
    a0 = 3'b110; b0 = 3'b001; a1 = 3'b111; b1 = 3'b000;
    op0 = 2'b10; op1 = 2'b10;
    for (int k = 0; k < 3; k++) begin
      w = vencedor(1);
      gq.push_back(w[0]);
      rq.push_back({w[0], modelo(w[0] ? a1 : a0, w[0] ? b1 : b0, 2'b10)});
      ult = w;
    end
    req0 = 1; req1 = 1;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(n);
      if (k > 0) chk("rr_gap", n, 3);
    end
    req0 = 0; req1 = 0;
    drain();

    issue(0, 3'b111, 3'b111, 2'b11);
    for (int k = 0; k < 8; k++)
      issue($urandom_range(0, 1), 3'($urandom), 3'($urandom),
            2'($urandom));

    gq.push_back(1'b0);
    a0 = 3'b011; b0 = 3'b100; op0 = 2'b00; req0 = 1;
    wait_gnt(n);
    req0 = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("ab_gnt", {gnt1, gnt0}, 0);
    chk("ab_val", valido, 0);
    chk("ab_res", resultado, 0);
    chk("ab_org", origem, 0);
    chk("ab_ocup", ocupado, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("ab_idle", ocupado, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
